// File: rtl/jtkiwi_shram_pkg.sv
// jtkiwi_shram_pkg
//   Shared definitions for the main/sound shared-RAM responder.
//   - SHRAM_AW : default shared RAM address width (8kB)
//   - st_e     : arbiter state, i.e. which requester currently owns the RAM port
package jtkiwi_shram_pkg;

  localparam int SHRAM_AW = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAIN = 2'd1,
    SND  = 2'd2
  } st_e;

endpackage

// File: rtl/jtframe_ram.sv
// jtframe_ram
//   Single-port byte-wide RAM with synchronous read (1 clock latency).
//   A write updates the output register with the written byte in the same
//   edge, so the cycle after a write already shows the post-write data.
//   Storage has no reset: contents survive rst_n.
// Ports
//   clk     in   1   clock
//   addr_i  in   AW  address
//   data_i  in   8   write data
//   we_i    in   1   write enable
//   q_o     out  8   registered read data
module jtframe_ram #(
  parameter int    AW      = 13,
  parameter string SIMFILE = ""
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    data_i,
  input  logic          we_i,
  output logic [7:0]    q_o
);

  logic [7:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= data_i;
      q_o           <= data_i;
    end else begin
      q_o <= mem_q[addr_i];
    end
  end

  // SIMFILE names an optional preload image. This module never initialises
  // storage itself; the block below only records whether an image was named
  // so the parameter stays part of the interface for callers that pass it.
  if (SIMFILE != "") begin : g_simfile_named
  end

endmodule

// File: rtl/jtkiwi_shram.sv
// jtkiwi_shram
//   Shared-RAM responder between the main CPU and the sound CPU. Owns the
//   8kB shared RAM, arbitrates the two requesters and serves their reads and
//   writes through a single RAM port.
// Ports
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous reset, active low
//   main_cs_i    in   1   main CPU request (level, held until main_ok_o)
//   main_addr_i  in   AW  main CPU address
//   main_we_i    in   1   main CPU write strobe
//   main_din_i   in   8   main CPU write data
//   main_dout_o  out  8   read data to main CPU
//   main_ok_o    out  1   main access served / read data valid
//   snd_cs_i     in   1   sound CPU request (level)
//   snd_addr_i   in   AW  sound CPU address
//   snd_rnw_i    in   1   sound CPU read-not-write
//   snd_din_i    in   8   sound CPU write data
//   snd_dout_o   out  8   read data to sound CPU
//   mshramen_o   out  1   sound CPU must wait (1 = busy)
//   st_o         out  2   current arbiter state (debug)
//
// Handshake: a requester raises cs (with address, data and write strobe) and
// holds all of them until it is released: main_ok_o=1 for the main side,
// mshramen_o=0 for the sound side. While released, the read data output is
// valid for the address presented one cycle earlier. Dropping cs ends the
// access; main_ok_o follows main_cs_i low in the same cycle.
module jtkiwi_shram
  import jtkiwi_shram_pkg::*;
#(
  parameter int    AW        = SHRAM_AW,
  parameter bit    MAIN_PRIO = 1'b1,
  parameter string SIMFILE   = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_cs_i,
  input  logic [AW-1:0] main_addr_i,
  input  logic          main_we_i,
  input  logic [7:0]    main_din_i,
  output logic [7:0]    main_dout_o,
  output logic          main_ok_o,
  input  logic          snd_cs_i,
  input  logic [AW-1:0] snd_addr_i,
  input  logic          snd_rnw_i,
  input  logic [7:0]    snd_din_i,
  output logic [7:0]    snd_dout_o,
  output logic          mshramen_o,
  output st_e           st_o
);

  // Arbiter state
  st_e  st_q, st_d;
  st_e  last_q, last_d;        // owner granted most recently
  logic main_vld_q, main_vld_d; // main has owned the port for at least a cycle
  logic snd_vld_q, snd_vld_d;

  // Read-data path
  st_e        rd_owner_q, rd_owner_d; // who addressed the RAM last cycle
  logic [7:0] main_hold_q, main_hold_d;
  logic [7:0] snd_hold_q, snd_hold_d;

  // RAM port
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_q;

  jtframe_ram #(
    .AW      (AW),
    .SIMFILE (SIMFILE)
  ) u_ram (
    .clk    (clk),
    .addr_i (ram_addr),
    .data_i (ram_din),
    .we_i   (ram_we),
    .q_o    (ram_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      last_q     <= SND;
      main_vld_q <= 1'b0;
      snd_vld_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      last_q     <= last_d;
      main_vld_q <= main_vld_d;
      snd_vld_q  <= snd_vld_d;
    end
  end

  // Next-state logic. Priority is only consulted when granting from IDLE;
  // an owner keeps the port until it drops its own cs, and the waiting side
  // is then handed the port directly without passing through IDLE.
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: begin
        if (main_cs_i && snd_cs_i) begin
          st_d = (MAIN_PRIO || last_q == SND) ? MAIN : SND;
        end else if (main_cs_i) begin
          st_d = MAIN;
        end else if (snd_cs_i) begin
          st_d = SND;
        end
      end
      MAIN: begin
        if (!main_cs_i) st_d = snd_cs_i ? SND : IDLE;
      end
      SND: begin
        if (!snd_cs_i) st_d = main_cs_i ? MAIN : IDLE;
      end
      default: st_d = IDLE;
    endcase

    last_d = last_q;
    if (st_d != st_q && st_d != IDLE) last_d = st_d;

    // Valid flags rise one cycle after entry (once the RAM has produced data
    // for the owner's address) and clear as soon as the owner lets go.
    main_vld_d = (st_q == MAIN) && main_cs_i;
    snd_vld_d  = (st_q == SND) && snd_cs_i;
  end

  // Output logic: RAM port mux, write enable and handshake outputs.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    case (st_q)
      MAIN: begin
        ram_addr = main_addr_i;
        ram_din  = main_din_i;
        ram_we   = main_we_i;
      end
      SND: begin
        ram_addr = snd_addr_i;
        ram_din  = snd_din_i;
        ram_we   = !snd_rnw_i;
      end
      default: ;
    endcase
    // Belt and braces: a write must never land while reset is asserted.
    ram_we = ram_we & rst_n;

    main_ok_o  = (st_q == MAIN) && main_vld_q && main_cs_i;
    // Combinational so the sound CPU sees busy in the very cycle it raises cs.
    mshramen_o = snd_cs_i && !((st_q == SND) && snd_vld_q);

    // The RAM output belongs to whoever addressed it last cycle; the other
    // side keeps showing its last read value.
    main_dout_o = (rd_owner_q == MAIN) ? ram_q : main_hold_q;
    snd_dout_o  = (rd_owner_q == SND)  ? ram_q : snd_hold_q;

    st_o = st_q;
  end

  // Read-data ownership and hold registers
  always_comb begin
    rd_owner_d  = st_q;
    main_hold_d = main_dout_o;
    snd_hold_d  = snd_dout_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q  <= IDLE;
      main_hold_q <= 8'h00;
      snd_hold_q  <= 8'h00;
    end else begin
      rd_owner_q  <= rd_owner_d;
      main_hold_q <= main_hold_d;
      snd_hold_q  <= snd_hold_d;
    end
  end

endmodule

// File: tb/tb_jtkiwi_shram.sv
// tb_jtkiwi_shram
//   Directed and randomized checks of the shared-RAM responder. A flat byte
//   array holds the expected RAM contents; latencies are derived from the
//   access rules (2 cycles uncontended, plus 2 cycles after the other owner
//   releases). A second instance with alternating priority shares the inputs.
module tb_jtkiwi_shram;
  import jtkiwi_shram_pkg::*;

  localparam int AW  = 13;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          main_cs = 1'b0;
  logic [AW-1:0] main_addr = '0;
  logic          main_we = 1'b0;
  logic [7:0]    main_din = '0;
  logic          snd_cs = 1'b0;
  logic [AW-1:0] snd_addr = '0;
  logic          snd_rnw = 1'b1;
  logic [7:0]    snd_din = '0;

  logic [7:0] main_dout, snd_dout, alt_main_dout, alt_snd_dout;
  logic       main_ok, mshramen, alt_main_ok, alt_mshramen;
  st_e        st, alt_st;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_mem [0:(1<<AW)-1];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  jtkiwi_shram #(.AW(AW), .MAIN_PRIO(1'b1), .SIMFILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .main_cs_i(main_cs), .main_addr_i(main_addr), .main_we_i(main_we),
    .main_din_i(main_din), .main_dout_o(main_dout), .main_ok_o(main_ok),
    .snd_cs_i(snd_cs), .snd_addr_i(snd_addr), .snd_rnw_i(snd_rnw),
    .snd_din_i(snd_din), .snd_dout_o(snd_dout), .mshramen_o(mshramen),
    .st_o(st)
  );

  jtkiwi_shram #(.AW(AW), .MAIN_PRIO(1'b0), .SIMFILE("")) dut_alt (
    .clk(clk), .rst_n(rst_n),
    .main_cs_i(main_cs), .main_addr_i(main_addr), .main_we_i(main_we),
    .main_din_i(main_din), .main_dout_o(alt_main_dout), .main_ok_o(alt_main_ok),
    .snd_cs_i(snd_cs), .snd_addr_i(snd_addr), .snd_rnw_i(snd_rnw),
    .snd_din_i(snd_din), .snd_dout_o(alt_snd_dout), .mshramen_o(alt_mshramen),
    .st_o(alt_st)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic main_req(input logic [AW-1:0] a, input logic w, input logic [7:0] d);
    main_cs = 1'b1; main_addr = a; main_we = w; main_din = d;
  endtask

  task automatic main_rel();
    main_cs = 1'b0; main_we = 1'b0;
  endtask

  task automatic main_wait_ok(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!main_ok && lat < TMO);
    check("main_ok_seen", main_ok, 1);
  endtask

  task automatic snd_req(input logic [AW-1:0] a, input logic w, input logic [7:0] d);
    snd_cs = 1'b1; snd_addr = a; snd_rnw = !w; snd_din = d;
  endtask

  task automatic snd_rel();
    snd_cs = 1'b0; snd_rnw = 1'b1;
  endtask

  task automatic snd_wait_free(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (mshramen && lat < TMO);
    check("snd_released", mshramen, 0);
  endtask

  task automatic main_access(input logic [AW-1:0] a, input logic w, input logic [7:0] d,
                             output logic [7:0] q, output int lat);
    @(negedge clk);
    main_req(a, w, d);
    main_wait_ok(lat);
    q = main_dout;
    main_rel();
    if (w) model_mem[a] = d;
  endtask

  task automatic snd_access(input logic [AW-1:0] a, input logic w, input logic [7:0] d,
                            output logic [7:0] q, output int lat);
    @(negedge clk);
    snd_req(a, w, d);
    #1 check("snd_busy_first_cycle", mshramen, 1);
    snd_wait_free(lat);
    q = snd_dout;
    snd_rel();
    if (w) model_mem[a] = d;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]    qm, qs;
    int            lm, ls, busy_cnt, a;
    logic [AW-1:0] a1, a2;
    logic [7:0]    d1, d2;
    st_e           exp_alt;
    logic          alt_last_main;

    // Reset state
    snd_cs = 1'b1;
    #12;
    check("rst_st", st, IDLE);
    check("rst_main_ok", main_ok, 0);
    check("rst_main_dout", main_dout, 8'h00);
    check("rst_snd_dout", snd_dout, 8'h00);
    check("rst_mshramen_follows_cs_hi", mshramen, 1);
    snd_cs = 1'b0;
    #1 check("rst_mshramen_follows_cs_lo", mshramen, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sound write then read, 2 busy cycles each
    snd_access(13'h0123, 1'b1, 8'h5A, qs, ls);
    check("t1_snd_wr_latency", ls, 2);
    snd_access(13'h0123, 1'b0, 8'h00, qs, ls);
    check("t1_snd_rd_latency", ls, 2);
    check("t1_snd_rd_data", qs, model_mem[13'h0123]);
    main_access(13'h0124, 1'b1, 8'h99, qm, lm);
    check("t1_main_wr_latency", lm, 2);
    check("t1_snd_dout_hold", snd_dout, 8'h5A);
    main_access(13'h0123, 1'b0, 8'h00, qm, lm);
    check("t1_main_rd_cross", qm, model_mem[13'h0123]);

    // Address change while granted
    main_access(13'h0200, 1'b1, 8'h21, qm, lm);
    main_access(13'h0201, 1'b1, 8'h34, qm, lm);
    @(negedge clk);
    main_req(13'h0200, 1'b0, 8'h00);
    main_wait_ok(lm);
    check("addr_chg_first", main_dout, model_mem[13'h0200]);
    main_addr = 13'h0201;
    @(negedge clk);
    check("addr_chg_follow", main_dout, model_mem[13'h0201]);
    check("addr_chg_ok_held", main_ok, 1);
    main_rel();
    #1 check("main_ok_drops_with_cs", main_ok, 0);

    // 2: simultaneous requests, main priority
    fork
      main_access(13'h0300, 1'b1, 8'hA1, qm, lm);
      snd_access(13'h0301, 1'b1, 8'hB2, qs, ls);
    join
    check("t2_main_latency", lm, 2);
    check("t2_snd_latency", ls, 4);
    main_access(13'h0301, 1'b0, 8'h00, qm, lm);
    check("t2_snd_write_landed", qm, model_mem[13'h0301]);

    // 4: main holds 0x1FFF while sound writes it
    main_access(13'h1FFF, 1'b1, 8'h11, qm, lm);
    @(negedge clk);
    main_req(13'h1FFF, 1'b0, 8'h00);
    main_wait_ok(lm);
    check("t4_main_first_read", main_dout, model_mem[13'h1FFF]);
    snd_req(13'h1FFF, 1'b1, 8'hC3);
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mshramen) busy_cnt++;
    end
    check("t4_snd_waits_while_main_holds", busy_cnt, 4);
    check("t4_main_still_ok", main_ok, 1);
    main_rel();
    snd_wait_free(ls);
    check("t4_snd_latency_after_release", ls, 2);
    snd_rel();
    model_mem[13'h1FFF] = 8'hC3;
    main_access(13'h1FFF, 1'b0, 8'h00, qm, lm);
    check("t4_main_reread", qm, 8'hC3);

    // 5a: reset at SND entry of a write, write abandoned
    main_access(13'h0456, 1'b1, 8'h77, qm, lm);
    main_access(13'h0456, 1'b0, 8'h00, qm, lm);
    @(negedge clk);
    snd_req(13'h0456, 1'b1, 8'hEE);
    @(negedge clk);
    check("t5_snd_entry", st, SND);
    rst_n = 1'b0;
    #1;
    check("t5_rst_st", st, IDLE);
    check("t5_rst_main_ok", main_ok, 0);
    check("t5_rst_main_dout", main_dout, 8'h00);
    check("t5_rst_busy", mshramen, 1);
    snd_rel();
    @(negedge clk);
    rst_n = 1'b1;
    main_access(13'h0456, 1'b0, 8'h00, qm, lm);
    check("t5_no_ram_change", qm, model_mem[13'h0456]);

    // 5b: reset at SND entry with the strobe held, access restarts
    @(negedge clk);
    snd_req(13'h0456, 1'b1, 8'hEE);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    snd_wait_free(ls);
    check("t5_restart_latency", ls, 2);
    snd_rel();
    model_mem[13'h0456] = 8'hEE;
    main_access(13'h0456, 1'b0, 8'h00, qm, lm);
    check("t5_restart_completes", qm, 8'hEE);

    // 3: alternating priority on the second instance
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    alt_last_main = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      main_cs = 1'b1; main_we = 1'b0; snd_cs = 1'b1; snd_rnw = 1'b1;
      @(negedge clk);
      exp_alt = alt_last_main ? SND : MAIN;
      check($sformatf("t3_alt_grant_%0d", r), alt_st, exp_alt);
      check($sformatf("t3_prio_grant_%0d", r), st, MAIN);
      alt_last_main = (exp_alt == MAIN);
      main_cs = 1'b0; snd_cs = 1'b0;
      @(negedge clk);
      check($sformatf("t3_alt_idle_%0d", r), alt_st, IDLE);
    end

    // 6: interleaved address sweep with random data and contention
    a = 0;
    while (a < (1 << AW)) begin
      a1 = a[AW-1:0];
      a2 = ~a1;
      d1 = 8'($urandom_range(0, 255));
      d2 = 8'($urandom_range(0, 255));
      fork
        main_access(a1, 1'b1, d1, qm, lm);
        snd_access(a2, 1'b1, d2, qs, ls);
      join
      fork
        main_access(a2, 1'b0, 8'h00, qm, lm);
        snd_access(a1, 1'b0, 8'h00, qs, ls);
      join
      check($sformatf("t6_main_rd_%04h", a2), qm, model_mem[a2]);
      check($sformatf("t6_snd_rd_%04h", a1), qs, model_mem[a1]);
      a += int'($urandom_range(1, 97));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
